// File: rtl/y_mux_arb.sv
// Two-requester round-robin arbiter in front of a SIZE-bit 2:1 mux, with a one-entry output register.
// Optional transfer/stall counters are enabled by defining Y_MUX_ARB_COUNT_EN.
module y_mux_arb #(
  parameter int unsigned SIZE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [SIZE-1:0] b,
  input  logic            b_valid,
  output logic            b_ready,
  output logic            c,
  output logic [SIZE-1:0] z,
  output logic            z_valid,
  input  logic            z_ready
`ifdef Y_MUX_ARB_COUNT_EN
  ,
  output logic [7:0]      cnt_a,
  output logic [7:0]      cnt_b,
  output logic [7:0]      cnt_stall
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [SIZE-1:0] z_q, z_d;
  logic [SIZE-1:0] mux_out;
  logic            can_load;
  logic            load;

  // Per-bit 2:1 mux array selected by the grant.
  for (genvar i = 0; i < SIZE; i++) begin : g_ymux2
    assign mux_out[i] = c ? b[i] : a[i];
  end

  // Round-robin grant: a lone requester wins, contention goes to the previous loser.
  always_comb begin
    c = last_q;
    case ({a_valid, b_valid})
      2'b10:   c = 1'b0;
      2'b01:   c = 1'b1;
      2'b11:   c = ~last_q;
      default: c = last_q;
    endcase
  end

  always_comb begin
    can_load = (state_q == StEmpty) | z_ready;
    // Readies are forced low while reset is asserted.
    a_ready  = rst_n & can_load & a_valid & ~c;
    b_ready  = rst_n & can_load & b_valid & c;
    load     = a_ready | b_ready;
    state_d  = state_q;
    last_d   = last_q;
    z_d      = z_q;
    case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (!load && z_ready) state_d = StEmpty;
    endcase
    if (load) begin
      z_d    = mux_out;
      last_d = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      last_q  <= 1'b1;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      z_q     <= z_d;
    end
  end

  assign z       = z_q;
  assign z_valid = (state_q == StFull);

`ifdef Y_MUX_ARB_COUNT_EN
  logic [7:0] cnt_a_q, cnt_b_q, cnt_stall_q;
  logic       stall;

  assign stall = (a_valid | b_valid) & ~can_load;

  // Free-running counters; wrap without saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q     <= 8'd0;
      cnt_b_q     <= 8'd0;
      cnt_stall_q <= 8'd0;
    end else begin
      if (a_ready) cnt_a_q     <= cnt_a_q + 8'd1;
      if (b_ready) cnt_b_q     <= cnt_b_q + 8'd1;
      if (stall)   cnt_stall_q <= cnt_stall_q + 8'd1;
    end
  end

  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;
  assign cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_y_mux_arb.sv
// Directed self-checking bench for y_mux_arb; counter checks run when Y_MUX_ARB_COUNT_EN is defined.
module tb_y_mux_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] a, b, z;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic       c, z_valid, z_ready;
`ifdef Y_MUX_ARB_COUNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  y_mux_arb #(.SIZE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b         (b),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .c         (c),
    .z         (z),
    .z_valid   (z_valid),
    .z_ready   (z_ready)
`ifdef Y_MUX_ARB_COUNT_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_stall (cnt_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_z [4];
  logic       exp_c [4];

  initial begin
    exp_z = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_c = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held with both sources requesting.
    rst_n = 1'b0; a = 2'b01; b = 2'b10; a_valid = 1'b1; b_valid = 1'b1; z_ready = 1'b1;
    step(); step();
    check("rst_z", z, 2'b00);
    check("rst_z_valid", z_valid, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);

    // Release between edges; contention alternates starting with A.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_c%0d", i), c, exp_c[i]);
      check($sformatf("cont_rdy%0d", i), {a_ready, b_ready}, exp_c[i] ? 2'b01 : 2'b10);
      step();
      check($sformatf("cont_z%0d", i), z, exp_z[i]);
      check($sformatf("cont_zv%0d", i), z_valid, 1'b1);
    end

    // One A transfer, then backpressure with both valid.
    step();
    check("bp_load_z", z, 2'b01);
    z_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_rdy%0d", i), {a_ready, b_ready}, 2'b00);
      check($sformatf("bp_c%0d", i), c, 1'b1);
      step();
      check($sformatf("bp_zv%0d", i), z_valid, 1'b1);
      check($sformatf("bp_z%0d", i), z, 2'b01);
    end
    z_ready = 1'b1;
    #1;
    check("bp_release_b_ready", b_ready, 1'b1);
    step();
    check("bp_release_z", z, 2'b10);
    check("bp_release_zv", z_valid, 1'b1);

    // Single requester B streams without bubbles.
    a_valid = 1'b0; b = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("solo_c%0d", i), c, 1'b1);
      check($sformatf("solo_b_ready%0d", i), b_ready, 1'b1);
      step();
      check($sformatf("solo_z%0d", i), z, 2'b11);
      check($sformatf("solo_zv%0d", i), z_valid, 1'b1);
    end

    // Idle drain after one A transfer.
    a_valid = 1'b1; b_valid = 1'b0; a = 2'b10;
    #1;
    check("drain_c", c, 1'b0);
    step();
    check("drain_load_z", z, 2'b10);
    a_valid = 1'b0;
    #1;
    check("drain_idle_c", c, 1'b0);
    check("drain_idle_rdy", {a_ready, b_ready}, 2'b00);
    step();
    check("drain_zv", z_valid, 1'b0);
    check("drain_z_hold", z, 2'b10);

    // Async reset between edges while z is full.
    a_valid = 1'b1; a = 2'b01;
    step();
    check("mid_pre_zv", z_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_zv", z_valid, 1'b0);
    check("mid_rst_z", z, 2'b00);
    check("mid_rst_a_ready", a_ready, 1'b0);
    rst_n = 1'b1; b_valid = 1'b1;
    #1;
    check("mid_post_c", c, 1'b0);

`ifdef Y_MUX_ARB_COUNT_EN
    check("cnt_rst_a", cnt_a, 8'd0);
    check("cnt_rst_stall", cnt_stall, 8'd0);
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    a_valid = 1'b0; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("cnt_a5", cnt_a, 8'd5);
    check("cnt_b3", cnt_b, 8'd3);
    z_ready = 1'b0;
    for (int i = 0; i < 2; i++) step();
    check("cnt_stall2", cnt_stall, 8'd2);
    check("cnt_b_hold", cnt_b, 8'd3);
    z_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b0;
    for (int i = 0; i < 251; i++) step();
    check("cnt_a_wrap", cnt_a, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y_mux_arb.md
Name: y_mux_arb

Overview:
- Two-requester round-robin arbiter that shares one SIZE-bit 2:1 mux datapath (yMux2 array) between source A and source B.
- Drives the mux select `c` and captures the mux result into a single-entry output register, with a valid/ready handshake on both sources and on the sink.
- Sits in front of any shared datapath consumer (ALU operand port, register-file write port) that two producers contend for.

Parameters:
- SIZE, 2, data width of each source and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  SIZE  source A data
- a_valid  input  1  source A request
- a_ready  output  1  source A accepted this cycle
- b  input  SIZE  source B data
- b_valid  input  1  source B request
- b_ready  output  1  source B accepted this cycle
- c  output  1  mux select: 0 = A, 1 = B; combinational grant
- z  output  SIZE  registered mux result
- z_valid  output  1  z holds unconsumed data
- z_ready  input  1  sink accepts z

Behaviour:
- Reset (async, rst_n=0):
  - z=0, z_valid=0, last=1. With last=1, A wins the first contested cycle.
  - a_ready=0 and b_ready=0 while reset is asserted.
- Output register states:
  - EMPTY (z_valid=0) and FULL (z_valid=1).
  - can_load = !z_valid | z_ready. A FULL register being drained can reload in the same cycle.
- Grant (combinational, same cycle):
  - Only A valid -> c=0. Only B valid -> c=1.
  - Both valid -> c = ~last, i.e. the source that did not win the previous transfer.
  - Neither valid -> c holds last.
- Ready outputs:
  - a_ready = can_load & a_valid & (c==0).
  - b_ready = can_load & b_valid & (c==1).
  - A ready is never asserted without the matching valid. At most one ready is high per cycle.
- Transfer (rising edge when a_ready|b_ready):
  - z <= (c ? b : a), z_valid <= 1, last <= c.
  - Latency from accepted request to z_valid is 1 cycle. Throughput is 1 transfer/cycle while z_ready=1.
- Drain with no new transfer (z_valid & z_ready & no source ready): z_valid <= 0 and z retains its old value.
- Backpressure (z_valid=1, z_ready=0):
  - Both readies are 0. z and z_valid hold.
  - The grant is still computed, but last does not change.
- Sources:
  - Must hold data stable while valid and not ready.
  - A source may drop valid without a transfer. The arbiter does not lock a grant.
- Fairness: under continuous contention with z_ready=1, grants alternate A,B,A,B... A source waits at most 1 transfer.
- Reset mid-operation: pending z is discarded (z_valid=0) and the round-robin pointer returns to last=1.
- X-handling: if a_valid or b_valid is X, c may be X. Benches must drive known values after reset.

Optional Feature:
- Macro: Y_MUX_ARB_COUNT_EN.
- When defined, adds three outputs:
  - cnt_a  output 8  count of A transfers
  - cnt_b  output 8  count of B transfers
  - cnt_stall  output 8  cycles with (a_valid|b_valid) & !can_load
- Counter behaviour:
  - All counters reset to 0 and increment by 1 on the qualifying edge.
  - Counters wrap 255 -> 0 without saturation.
- When not defined: the ports and counter logic are absent, and the behaviour above is unchanged.

Test Plan:
- Reset: hold rst_n=0 with a_valid=b_valid=1 and z_ready=1 -> z=0, z_valid=0, a_ready=b_ready=0. Release -> first edge loads z=a (a=2'b01, b=2'b10 gives z=01), with c=0 in that cycle.
- Contention: a=01, b=10, both valid, z_ready=1 for 4 cycles -> z sequence 01,10,01,10 and c sequence 0,1,0,1.
- Backpressure: after one transfer, z_ready=0 for 3 cycles with both valid -> z_valid=1, z stable, a_ready=b_ready=0 throughout. Raising z_ready -> the next load is from the source opposite last, in the same cycle as the drain.
- Single requester: only b_valid=1 (b=11) for 3 cycles -> c=1 each cycle, z=11, b_ready=1 every cycle, no bubble.
- Idle drain: one A transfer (a=10), then both valid=0 with z_ready=1 -> z_valid falls the next edge and z stays 10.
- Async reset mid-stream: pulse rst_n low between clock edges while z_valid=1 -> z_valid=0 and z=0 immediately. With Y_MUX_ARB_COUNT_EN defined: after 5 A and 3 B transfers, cnt_a=5, cnt_b=3, and 256 A transfers wrap cnt_a to 0.
